// File: rtl/npc_pkg.sv
// npc_pkg: shared IFU state type, reset PC default and nop encoding
package npc_pkg;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} ifu_state_t;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
endpackage

// File: rtl/ifu.sv
// ifu: single-outstanding instruction fetch FSM; define IFU_MISALIGN_CHK_EN to fault on misaligned redirects
module ifu
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);
  ifu_state_t  state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d, tgt;
  logic        kill_q, kill_d, halt_q, halt_d, fault_q, fault_d, mis;
`ifdef IFU_MISALIGN_CHK_EN
  assign tgt = redirect_pc;
  assign mis = redirect_pc[1:0] != 2'b00;
`else
  assign tgt = redirect_pc & 32'hFFFF_FFFC;
  assign mis = 1'b0;
`endif
  // state, pc, held instruction, kill/halt flags and fault pulse registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= INST_NOP;
      kill_q  <= 1'b0;
      halt_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      kill_q  <= kill_d;
      halt_q  <= halt_d;
      fault_q <= fault_d;
    end
  // next state: a request accepted alongside a redirect stays outstanding but is marked killed
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    kill_d  = kill_q;
    halt_d  = halt_q;
    fault_d = 1'b0;
    case (state_q)
      S_REQ: begin
        if (redirect_valid) begin
          pc_d    = tgt;
          halt_d  = mis;
          fault_d = mis;
        end
        if (!halt_q && imem_req_ready) begin
          state_d = S_WAIT;
          kill_d  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d    = tgt;
          halt_d  = mis;
          fault_d = mis;
          kill_d  = 1'b1;
        end
        if (imem_rsp_valid) begin
          kill_d  = 1'b0;
          state_d = (redirect_valid || kill_q || imem_rsp_err) ? S_REQ : S_HOLD;
          if (!redirect_valid && !kill_q) begin
            inst_d  = imem_rsp_err ? inst_q : imem_rsp_data;
            halt_d  = imem_rsp_err;
            fault_d = imem_rsp_err;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = tgt;
          halt_d  = mis;
          fault_d = mis;
          state_d = S_REQ;
        end else if (inst_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end
  // outputs: requests are held off during reset and while halted after a fault
  always_comb begin
    imem_req_valid = rst_n && state_q == S_REQ && !halt_q;
    imem_req_addr  = pc_q;
    inst_valid     = state_q == S_HOLD;
    inst           = inst_q;
    pc             = pc_q;
    fetch_fault    = fault_q;
  end
endmodule
